// File: rtl/soc_fabric_pkg.sv
// soc_fabric_pkg: shared constants for the SoC fabric.
//   - Status/slot register offsets, as seen on addr[3:2] (reg_sel).
//   - Per-slot state encoding used by slot_tracker and exposed as its debug
//     output.
//   - Width of the per-slot timeout counter.
package soc_fabric_pkg;

  // Offset 0 inside a slot window is GO; offsets 0..3 inside the status
  // window are DONE, ERR, MASK and W1C.
  localparam logic [1:0] REG_GO   = 2'd0;
  localparam logic [1:0] REG_DONE = 2'd0;
  localparam logic [1:0] REG_ERR  = 2'd1;
  localparam logic [1:0] REG_MASK = 2'd2;
  localparam logic [1:0] REG_W1C  = 2'd3;

  localparam int CNT_W = 16;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_BUSY = 1'b1
  } slot_state_t;

endpackage

// File: rtl/slot_tracker.sv
// slot_tracker: tracks one accelerator slot.
//   clk, reset   : clock, asynchronous active-low reset
//   go           : GO write for this slot (honoured only while IDLE)
//   clr          : write-1-to-clear pulse for this slot's done/err flags
//   done_lvl     : level done signal from the accelerator
//   state        : current slot state (debug/observability, also busy)
//   done_flag    : sticky done flag
//   err_flag     : sticky timeout flag
//
// A rising edge of done_lvl sets done_flag (even while IDLE) and ends a BUSY
// period. While BUSY the counter runs down from TIMEOUT; the edge on which it
// reaches 0 sets err_flag and returns to IDLE, leaving the counter at 0.
// Same-edge priority: an accepted GO clears both flags and beats a done
// edge; a set (done edge / timeout) beats a W1C clear.
module slot_tracker
  import soc_fabric_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        clr,
  input  logic        done_lvl,
  output slot_state_t state,
  output logic        done_flag,
  output logic        err_flag
);

  slot_state_t      state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             done_q;
  logic             armed;
  logic             done_nx, err_nx;
  logic             rise, go_ok, expire;

  // 'armed' is low for the first edge after reset release so that a done
  // line already high at release only loads the history and is not taken
  // as a fresh edge.
  always_comb begin
    rise     = armed & done_lvl & ~done_q;
    go_ok    = go & (state == SLOT_IDLE);
    expire   = (state == SLOT_BUSY) && (cnt == CNT_W'(1));
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = done_flag;
    err_nx   = err_flag;

    case (state)
      SLOT_IDLE: begin
        if (go) begin
          state_nx = SLOT_BUSY;
          cnt_nx   = CNT_W'(TIMEOUT);
        end
      end
      SLOT_BUSY: begin
        cnt_nx = cnt - CNT_W'(1);
        if (rise || expire) state_nx = SLOT_IDLE;
      end
      default: state_nx = SLOT_IDLE;
    endcase

    if (go_ok)     done_nx = 1'b0;
    else if (rise) done_nx = 1'b1;
    else if (clr)  done_nx = 1'b0;

    if (go_ok)       err_nx = 1'b0;
    else if (expire) err_nx = 1'b1;
    else if (clr)    err_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SLOT_IDLE;
      cnt       <= '0;
      done_q    <= 1'b0;
      armed     <= 1'b0;
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      done_q    <= done_lvl;
      armed     <= 1'b1;
      done_flag <= done_nx;
      err_flag  <= err_nx;
    end
  end

endmodule

// File: rtl/soc_fabric.sv
// soc_fabric: address decoder and status block for NUM_SLOTS accelerators.
//   clk, reset      : clock, asynchronous active-low reset
//   addr/write_data : byte address and write data of the current access
//   WE              : write strobe
//   mem_rdata       : read data from memory
//   slot_rdata      : read data from each slot, slot k at [32k+31:32k]
//   slot_done       : level done from each accelerator
//   we_mem/we_slot  : decoded write enables (at most one high)
//   reg_sel         : addr[3:2]
//   data_out        : decoded read data
//   done_flags, err_flags : sticky per-slot flags
//   irq             : registered OR of masked flags
//
// Bus: single-cycle access with no valid/ready handshake. WE qualifies a
// write in the cycle it is high; reads are purely combinational from addr.
// A slot window is SLOT_BASE+k on addr[31:4]; the status window is
// STAT_BASE; everything else is memory.
module soc_fabric
  import soc_fabric_pkg::*;
#(
  parameter int          NUM_SLOTS = 4,
  parameter logic [27:0] SLOT_BASE = 28'h0000_080,
  parameter logic [27:0] STAT_BASE = 28'h0000_0F0,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            addr,
  input  logic [31:0]            write_data,
  input  logic                   WE,
  input  logic [31:0]            mem_rdata,
  input  logic [32*NUM_SLOTS-1:0] slot_rdata,
  input  logic [NUM_SLOTS-1:0]   slot_done,
  output logic                   we_mem,
  output logic [NUM_SLOTS-1:0]   we_slot,
  output logic [1:0]             reg_sel,
  output logic [31:0]            data_out,
  output logic [NUM_SLOTS-1:0]   done_flags,
  output logic [NUM_SLOTS-1:0]   err_flags,
  output logic                   irq
);

  localparam logic [28:0] SLOT_END = {1'b0, SLOT_BASE} + 29'(NUM_SLOTS);

  logic [27:0]          a_hi, slot_off;
  logic [2:0]           slot_idx;
  logic                 slot_hit, stat_hit, mem_hit;
  logic                 stat_wr;
  logic [NUM_SLOTS-1:0] clr_vec, go_vec, busy, irq_mask;
  logic [31:0]          stat_word;
  slot_state_t          slot_state [NUM_SLOTS];

  assign a_hi     = addr[31:4];
  assign reg_sel  = addr[3:2];
  assign slot_off = a_hi - SLOT_BASE;
  assign slot_idx = slot_off[2:0];
  assign slot_hit = (a_hi >= SLOT_BASE) && ({1'b0, a_hi} < SLOT_END);
  // A slot window overlapping the status window takes precedence.
  assign stat_hit = !slot_hit && (a_hi == STAT_BASE);
  assign mem_hit  = !slot_hit && !stat_hit;
  assign we_mem   = WE & mem_hit;
  assign stat_wr  = WE & stat_hit;

  // One W1C write bit k clears both done and err of slot k.
  assign clr_vec = (stat_wr && reg_sel == REG_W1C) ?
                   write_data[NUM_SLOTS-1:0] : '0;

  always_comb begin
    we_slot = '0;
    go_vec  = '0;
    busy    = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      we_slot[k] = WE & slot_hit & (slot_idx == 3'(k));
      go_vec[k]  = we_slot[k] & (reg_sel == REG_GO);
      busy[k]    = (slot_state[k] == SLOT_BUSY);
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    slot_tracker #(.TIMEOUT(TIMEOUT)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .go        (go_vec[k]),
      .clr       (clr_vec[k]),
      .done_lvl  (slot_done[k]),
      .state     (slot_state[k]),
      .done_flag (done_flags[k]),
      .err_flag  (err_flags[k])
    );
  end

  always_comb begin
    stat_word = '0;
    case (reg_sel)
      REG_DONE: stat_word[NUM_SLOTS-1:0] = done_flags;
      REG_ERR:  stat_word[NUM_SLOTS-1:0] = err_flags;
      REG_MASK: stat_word[NUM_SLOTS-1:0] = irq_mask;
      default:  stat_word[NUM_SLOTS-1:0] = busy;
    endcase

    data_out = mem_rdata;
    if (stat_hit) data_out = stat_word;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_hit && slot_idx == 3'(k)) data_out = slot_rdata[32*k +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (stat_wr && reg_sel == REG_MASK) irq_mask <= write_data[NUM_SLOTS-1:0];
      irq <= |((done_flags | err_flags) & irq_mask);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], write_data[31:NUM_SLOTS], slot_off[27:3]};

endmodule

// File: doc/soc_fabric.md
SOC_FABRIC -- requirements
Module: soc_fabric

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of accelerator slots (legal range 1..8).
REQ-002 SHALL have parameter SLOT_BASE, default 28'h0000_080, value of addr[31:4] for slot 0; slot k sits at SLOT_BASE+k.
REQ-003 SHALL have parameter STAT_BASE, default 28'h0000_0F0, value of addr[31:4] for the status block.
REQ-004 SHALL have parameter TIMEOUT, default 1024, cycles a slot may stay busy before its error flag sets (legal range 2..65535).
REQ-005 SHALL have ports: clk input 1, system clock; reset input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: addr input 32, byte address; write_data input 32; WE input 1, write strobe.
REQ-007 SHALL have ports: mem_rdata input 32; slot_rdata input 32*NUM_SLOTS, slot k in bits [32k+31:32k]; slot_done input NUM_SLOTS, level done from each accelerator.
REQ-008 SHALL have ports: we_mem output 1; we_slot output NUM_SLOTS; reg_sel output 2, equal to addr[3:2]; data_out output 32; done_flags output NUM_SLOTS; err_flags output NUM_SLOTS; irq output 1.

Function
REQ-009 SHALL decode combinationally: slot hit when SLOT_BASE <= addr[31:4] < SLOT_BASE+NUM_SLOTS; status hit when addr[31:4]==STAT_BASE; otherwise memory.
REQ-010 SHALL assert we_mem = WE on a memory hit, and we_slot[k] = WE on a slot-k hit; at most one write enable high in any cycle.
REQ-011 SHALL drive data_out combinationally: memory hit -> mem_rdata; slot-k hit -> slot_rdata[k]; status hit -> status register selected by reg_sel.
REQ-012 SHALL map status registers: reg_sel 0 = done_flags (RO, zero-extended); 1 = err_flags (RO); 2 = irq_mask (RW, NUM_SLOTS bits); 3 = write-1-to-clear for done and err (read returns busy vector).
REQ-013 SHALL keep per-slot state machine IDLE -> BUSY -> IDLE, one 16-bit timeout counter per slot.
REQ-014 SHALL treat a write to slot k with reg_sel==0 (GO) as start: state BUSY, done_flags[k] and err_flags[k] cleared, counter loaded with TIMEOUT, all on the next clock edge.
REQ-015 SHALL register slot_done (1-flop history) and detect a rising edge synchronously; a rising edge sets done_flags[k] and returns the slot to IDLE.
REQ-016 SHALL decrement the counter each cycle in BUSY; on reaching 0 it SHALL set err_flags[k], return to IDLE and hold the counter at 0.
REQ-017 SHALL ignore done edges while IDLE for state purposes but still set done_flags[k].
REQ-018 SHALL on the same edge give priority: set (done edge or timeout) > W1C clear; GO clear > done edge on the same slot in the same cycle.
REQ-019 SHALL ignore GO writes to a slot already BUSY, apart from forwarding we_slot[k].
REQ-020 SHALL drive irq registered: irq = |((done_flags | err_flags) & irq_mask), one cycle after the flag change.
REQ-021 SHALL ignore writes to read-only status registers, with no side effects.

Reset
REQ-022 SHALL on reset low, asynchronously: all slots IDLE, counters 0, done_flags 0, err_flags 0, irq_mask 0, irq 0, done history 0.
REQ-023 SHALL keep decode outputs (we_mem, we_slot, reg_sel, data_out) combinational and unaffected by reset.
REQ-024 SHALL abandon in-flight operations on reset mid-BUSY; a done edge arriving within the first cycle after release SHALL NOT set a flag if slot_done was already high.

Structure
REQ-025 SHALL place register offset constants (GO, DONE, ERR, MASK, W1C) and slot-state encodings in a shared package soc_fabric_pkg.
REQ-026 SHALL implement per-slot state, counter and edge detect in one sub-module slot_tracker, instantiated NUM_SLOTS times via generate.

Verification
REQ-027 Write GO to slot 1 (addr 0x90), slot_done[1] pulses high 5 cycles later -> done_flags=4'b0010 next edge, busy clears, data_out at 0xF00 = 0x2.
REQ-028 irq_mask=4'b0010 written at 0xF08, then REQ-027 -> irq high one cycle after the flag; W1C 0x2 to 0xF0C -> irq low next cycle.
REQ-029 TIMEOUT=8, GO to slot 0, no done -> err_flags[0]=1 exactly 8 cycles after GO, state IDLE.
REQ-030 Done edge on slot 2 and W1C of bit 2 in the same cycle -> done_flags[2] stays 1.
REQ-031 Reset pulled low while slot 3 BUSY with counter 500 -> all flags 0 and IDLE immediately, without a clock edge.
REQ-032 addr 0xC0 with NUM_SLOTS=4 -> memory hit, we_mem=WE, data_out=mem_rdata.
